// File: rtl/alu_pkg.sv
// alu_pkg: opcode, state and width definitions shared by the ALU pipe.
// Multiply opcodes are only legal when ALU_PIPE_MUL_EN is defined.
package alu_pkg;

  localparam int ALU_CTRL_W = 5;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD   = 5'b00000,
    ALU_SUB   = 5'b00001,
    ALU_AND   = 5'b00010,
    ALU_OR    = 5'b00011,
    ALU_XOR   = 5'b00100,
    ALU_SL    = 5'b00101,
    ALU_SRL   = 5'b00110,
    ALU_SRA   = 5'b00111,
    ALU_SLT   = 5'b01000,
    ALU_SLTU  = 5'b01001,
    ALU_BEQ   = 5'b01010,
    ALU_BNE   = 5'b01011,
    ALU_BLT   = 5'b01100,
    ALU_BGE   = 5'b01101,
    ALU_BLTU  = 5'b01110,
    ALU_BGEU  = 5'b01111,
    ALU_MUL   = 5'b10000,
    ALU_MULH  = 5'b10001,
    ALU_MULHU = 5'b10010
  } alu_op_t;

  typedef enum logic {
    IDLE,
    BUSY
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle.
// Works on magnitudes; signed mode negates the full product at the end.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign_mode,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               busy_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign a_mag = (sign_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign_mode && b[WIDTH-1]) ? -b : b;

  // Low half of acc holds the remaining multiplier bits.
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_nx = {sum, acc_q[WIDTH-1:1]};

  assign done = busy_q && (cnt_q == CNT_W'(WIDTH-1));
  assign product = neg_q ? -acc_nx : acc_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (start) begin
      busy_q  <= 1'b1;
      neg_q   <= sign_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
      cnt_q   <= '0;
      mcand_q <= a_mag;
      acc_q   <= {{WIDTH{1'b0}}, b_mag};
    end else if (busy_q) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result, compare and illegal flags.
// Define ALU_PIPE_MUL_EN to enable the iterative MUL/MULH/MULHU path.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] control,
  input  logic [WIDTH-1:0]      in_1,
  input  logic [WIDTH-1:0]      in_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  cond,
  output logic                  illegal,
  output logic                  busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_op_t      op;
  alu_state_t   state_q;
  alu_state_t   state_nx;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   res;
  logic               res_cond;
  logic               res_ill;
  logic               mul_hit;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_word;
  logic               fire_in;
  logic               lt_s;
  logic               lt_u;
  logic               eq;

  assign op    = alu_op_t'(control);
  assign shamt = in_2[SHAMT_W-1:0];
  assign lt_s  = $signed(in_1) < $signed(in_2);
  assign lt_u  = in_1 < in_2;
  assign eq    = in_1 == in_2;

  assign in_ready = (state_q == IDLE)
                 && (!out_valid || out_ready);
  assign fire_in  = in_valid && in_ready;

  always_comb begin
    res      = '0;
    res_cond = 1'b0;
    res_ill  = 1'b0;
    mul_hit  = 1'b0;
    unique case (op)
      ALU_ADD:  res = in_1 + in_2;
      ALU_SUB:  res = in_1 - in_2;
      ALU_AND:  res = in_1 & in_2;
      ALU_OR:   res = in_1 | in_2;
      ALU_XOR:  res = in_1 ^ in_2;
      ALU_SL:   res = in_1 << shamt;
      ALU_SRL:  res = in_1 >> shamt;
      ALU_SRA:  res = $signed(in_1) >>> shamt;
      ALU_SLT:  res_cond = lt_s;
      ALU_SLTU: res_cond = lt_u;
      ALU_BEQ:  res_cond = eq;
      ALU_BNE:  res_cond = !eq;
      ALU_BLT:  res_cond = lt_s;
      ALU_BGE:  res_cond = !lt_s;
      ALU_BLTU: res_cond = lt_u;
      ALU_BGEU: res_cond = !lt_u;
      ALU_MUL, ALU_MULH, ALU_MULHU: begin
`ifdef ALU_PIPE_MUL_EN
        mul_hit = 1'b1;
`else
        res_ill = 1'b1;
`endif
      end
      default:  res_ill = 1'b1;
    endcase
    // Compares return the outcome as a 0/1 word.
    if (control[4:3] == 2'b01) res = WIDTH'(res_cond);
  end

`ifdef ALU_PIPE_MUL_EN
  logic               mul_start;
  logic               mul_hi_q;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = fire_in && mul_hit;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start    (mul_start),
    .a        (in_1),
    .b        (in_2),
    .sign_mode(op == ALU_MULH),
    .done     (mul_done),
    .product  (mul_prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mul_hi_q <= 1'b0;
    else if (mul_start) mul_hi_q <= (op != ALU_MUL);
  end

  assign mul_word = mul_hi_q ? mul_prod[2*WIDTH-1:WIDTH]
                             : mul_prod[WIDTH-1:0];
  assign busy = (state_q == BUSY);
`else
  assign mul_done = 1'b0;
  assign mul_word = '0;
  assign busy     = 1'b0;
`endif

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE: if (fire_in && mul_hit) state_nx = BUSY;
      BUSY: if (mul_done) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      out       <= '0;
      cond      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (fire_in && !mul_hit) begin
        out       <= res;
        cond      <= res_cond;
        illegal   <= res_ill;
        out_valid <= 1'b1;
      end else if (mul_done) begin
        out       <= mul_word;
        cond      <= 1'b0;
        illegal   <= 1'b0;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: random and directed stimulus against a queue-based model.
// Multiply expectations follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    control;
  logic [W-1:0]  in_1;
  logic [W-1:0]  in_2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          cond;
  logic          illegal;
  logic          busy;

  alu_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .control  (control),
    .in_1     (in_1),
    .in_2     (in_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .cond     (cond),
    .illegal  (illegal),
    .busy     (busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         ill;
    logic         is_mul;
    int           due;
    logic         lit_en;
    logic [W-1:0] lit_out;
    logic         lit_c;
    logic         lit_ill;
  } ent_t;

  ent_t q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rdy_mode = 1;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         lit_en = 1'b0;
  logic [W-1:0] lit_out = '0;
  logic         lit_c = 1'b0;
  logic         lit_ill = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       out_ready = 1'b1;
      2:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t model(logic [4:0] op, logic [W-1:0] a,
                                 logic [W-1:0] b);
    ent_t e;
    int sh;
    longint sa;
    longint sb;
    longint sp;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    e = '{default: '0};
    sh = int'(b[4:0]);
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    sp = sa * sb;
    up = ua * ub;
    case (op)
      5'd0:  e.res = a + b;
      5'd1:  e.res = a - b;
      5'd2:  e.res = a & b;
      5'd3:  e.res = a | b;
      5'd4:  e.res = a ^ b;
      5'd5:  e.res = a << sh;
      5'd6:  e.res = a >> sh;
      5'd7:  e.res = $unsigned($signed(a) >>> sh);
      5'd8:  e.c = (sa < sb);
      5'd9:  e.c = (ua < ub);
      5'd10: e.c = (a == b);
      5'd11: e.c = (a != b);
      5'd12: e.c = (sa < sb);
      5'd13: e.c = (sa >= sb);
      5'd14: e.c = (ua < ub);
      5'd15: e.c = (ua >= ub);
      5'd16, 5'd17, 5'd18: begin
        if (MUL_EN) begin
          e.is_mul = 1'b1;
          if (op == 5'd16) e.res = up[31:0];
          else if (op == 5'd17) e.res = sp[63:32];
          else e.res = up[63:32];
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    if (op >= 5'd8 && op <= 5'd15) e.res = {31'b0, e.c};
    return e;
  endfunction

  always @(negedge clk) begin
    logic hold;
    logic bexp;
    ent_t e;
    if (!reset) begin
      q.delete();
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
    end else begin
      hold = (q.size() > 0) && (cyc >= q[0].due);
      bexp = (q.size() > 0) && q[0].is_mul && (cyc < q[0].due);
      chk("out_valid", {31'b0, out_valid}, {31'b0, hold});
      chk("busy", {31'b0, busy}, {31'b0, bexp});
      chk("in_ready", {31'b0, in_ready},
          {31'b0, !bexp && (!hold || out_ready)});
      if (hold && out_valid) begin
        chk("out", out, q[0].res);
        chk("cond", {31'b0, cond}, {31'b0, q[0].c});
        chk("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
        if (q[0].lit_en) begin
          chk("lit_out", out, q[0].lit_out);
          chk("lit_cond", {31'b0, cond}, {31'b0, q[0].lit_c});
          chk("lit_illegal", {31'b0, illegal}, {31'b0, q[0].lit_ill});
        end
      end
      if (hold && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(control, in_1, in_2);
        e.due = cyc + (e.is_mul ? W + 1 : 1);
        e.lit_en = lit_en;
        e.lit_out = lit_out;
        e.lit_c = lit_c;
        e.lit_ill = lit_ill;
        q.push_back(e);
      end
    end
  end

  task automatic present(logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b,
                         logic le, logic [W-1:0] lo, logic lc, logic li);
    control = op;
    in_1 = a;
    in_2 = b;
    lit_en = le;
    lit_out = lo;
    lit_c = lc;
    lit_ill = li;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lit_en = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    mismatched++;
    $display("FAIL accept_timeout: got no accept want accept");
    in_valid = 1'b0;
    lit_en = 1'b0;
  endtask

  task automatic issue(logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b,
                       logic le, logic [W-1:0] lo, logic lc, logic li);
    present(op, a, b, le, lo, lc, li);
    wait_accept();
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    mismatched++;
    $display("FAIL drain_timeout: got %0d pending want 0", q.size());
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int r;
    reset = 1'b0;
    in_valid = 1'b0;
    control = '0;
    in_1 = '0;
    in_2 = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_out", out, 0);
    chk("reset_cond", {31'b0, cond}, 0);
    chk("reset_illegal", {31'b0, illegal}, 0);
    chk("reset_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    issue(5'd0, 32'd7, 32'hFFFFFFFD, 1, 32'd4, 0, 0);
    issue(5'd1, 32'd0, 32'd1, 1, 32'hFFFFFFFF, 0, 0);
    issue(5'd7, 32'h80000000, 32'd35, 1, 32'hF0000000, 0, 0);
    issue(5'd6, 32'h80000000, 32'd35, 1, 32'h10000000, 0, 0);
    issue(5'd14, 32'd1, 32'hFFFFFFFF, 1, 32'd1, 1, 0);
    issue(5'd12, 32'd1, 32'hFFFFFFFF, 1, 32'd0, 0, 0);
    issue(5'd13, 32'd1, 32'hFFFFFFFF, 1, 32'd1, 1, 0);
    issue(5'd31, 32'd5, 32'd6, 1, 32'd0, 0, 1);
    issue(5'd0, 32'd1, 32'd2, 1, 32'd3, 0, 0);
    if (MUL_EN) begin
      issue(5'd16, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFE, 0, 0);
      issue(5'd17, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFF, 0, 0);
      issue(5'd18, 32'hFFFFFFFF, 32'd2, 1, 32'h00000001, 0, 0);
    end else begin
      issue(5'd16, 32'hFFFFFFFF, 32'd2, 1, 32'd0, 0, 1);
      issue(5'd17, 32'hFFFFFFFF, 32'd2, 1, 32'd0, 0, 1);
      issue(5'd18, 32'hFFFFFFFF, 32'd2, 1, 32'd0, 0, 1);
    end
    drain();

    rdy_mode = 2;
    issue(5'd0, 32'd1, 32'd1, 1, 32'd2, 0, 0);
    present(5'd0, 32'd2, 32'd2, 1, 32'd4, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready", {31'b0, in_ready}, 0);
    chk("bp_out_held", out, 32'd2);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    wait_accept();
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_second", out, 32'd4);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    drain();

    issue(MUL_EN ? 5'd16 : 5'd0, $urandom, $urandom, 0, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("abort_in_ready", {31'b0, in_ready}, 1);
    issue(5'd0, 32'd5, 32'd6, 1, 32'd11, 0, 0);
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 85) op = 5'($urandom_range(0, 15));
      else if (r < 95) op = 5'($urandom_range(16, 18));
      else op = 5'($urandom_range(19, 31));
      a = rnd_opnd();
      b = ($urandom_range(0, 7) == 0) ? a : rnd_opnd();
      issue(op, a, b, 0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 1;
    drain();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
